// File: rtl/copy_sink.sv
`default_nettype none
// ============================================================================
// Module : copy_sink
// Brief  : Clocked terminus of a Send/Ack 4-phase pipeline feeding a valid/ready FIFO.
// Rev    : 1.0
// ============================================================================
module copy_sink #(
   parameter int DW          = 16,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4
) (
   input  logic                     CLK,
   input  logic                     MR_n,
   input  logic                     Send_in,
   input  logic [DW-1:0]            Data_in,
   output logic                     Ack_out,
   output logic [DW-1:0]            Dout,
   output logic                     Dout_valid,
   input  logic                     Dout_ready,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      S_RESYNC = 2'd0,
      S_IDLE   = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SW-1:0]          settle_q;
   logic                   s_send;
   logic                   settled;

   state_t                 state_q, state_d;
   logic                   ack_q, ack_d;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   mem_empty;
   logic                   load;

   logic [DW-1:0]          mem_q [DEPTH];
   logic [AW:0]            wr_ptr_q, rd_ptr_q;
   logic [AW:0]            count_q, count_d;
   logic [DW-1:0]          dout_q;
   logic                   valid_q;

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Send_in};
      end
   end

   assign s_send = sync_q[SYNC_STAGES-1];

   // The synchronizer only reflects Send_in once it has been refilled after
   // reset; until then a low s_send is just the cleared flops, not the sender.
   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         settle_q <= '0;
      end else if (!settled) begin
         settle_q <= settle_q + 1'b1;
      end
   end

   assign settled = (settle_q == SW'(SYNC_STAGES));

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign pop       = valid_q & Dout_ready;
   assign mem_empty = (wr_ptr_q == rd_ptr_q);
   assign load      = !mem_empty && (!valid_q || pop);

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      push    = 1'b0;
      case (state_q)
         S_RESYNC: begin
            ack_d = 1'b0;
            if (settled && !s_send) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            ack_d = 1'b0;
            if (s_send && !full) begin
               push    = 1'b1;
               ack_d   = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            ack_d = 1'b1;
            if (!s_send) begin
               ack_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = S_RESYNC;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         state_q <= S_RESYNC;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   // Data_in is bundled with Send_in and held until Ack rises, so it is
   // captured without synchronization.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= Data_in;
      end
   end

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         wr_ptr_q <= '0;
      end else if (push) begin
         wr_ptr_q <= wr_ptr_q + 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Head register: Count covers the words in memory plus this register,
   // so the head word is presented one cycle after it is written.
   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         dout_q   <= '0;
         valid_q  <= 1'b0;
         rd_ptr_q <= '0;
      end else if (load) begin
         dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
         valid_q  <= 1'b1;
         rd_ptr_q <= rd_ptr_q + 1'b1;
      end else if (pop) begin
         valid_q  <= 1'b0;
      end
   end

   assign Ack_out    = ack_q;
   assign Dout       = dout_q;
   assign Dout_valid = valid_q;
   assign Count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_copy_sink.sv
`default_nettype none
// ============================================================================
// Module : tb_copy_sink
// Brief  : Scoreboard bench for copy_sink with directed handshake vectors.
// Rev    : 1.0
// ============================================================================
module tb_copy_sink;

   localparam int DW = 16;
   localparam int DEPTH = 4;

   logic          CLK = 1'b0;
   logic          MR_n;
   logic          Send_in;
   logic [DW-1:0] Data_in;
   logic          Ack_out;
   logic [DW-1:0] Dout;
   logic          Dout_valid;
   logic          Dout_ready;
   logic [2:0]    Count;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   copy_sink #(.DW(DW), .SYNC_STAGES(2), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .MR_n(MR_n), .Send_in(Send_in), .Data_in(Data_in),
      .Ack_out(Ack_out), .Dout(Dout), .Dout_valid(Dout_valid),
      .Dout_ready(Dout_ready), .Count(Count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output word must match the oldest expected one.
   always @(negedge CLK) begin
      if (MR_n && Dout_valid && Dout_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", Dout);
         end else begin
            check("dout_word", {16'h0, Dout}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack(input logic val, input int max);
      for (int i = 0; i < max; i++) begin
         if (Ack_out == val) break;
         tick(1);
      end
      check("ack_wait", {31'h0, Ack_out}, {31'h0, val});
   endtask

   task automatic send_token(input logic [DW-1:0] d);
      Data_in = d;
      Send_in = 1'b1;
      exp_q.push_back(d);
      wait_ack(1'b1, 20);
      Send_in = 1'b0;
      wait_ack(1'b0, 20);
   endtask

   task automatic drain();
      Dout_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (Count == 0 && !Dout_valid) break;
         tick(1);
      end
      Dout_ready = 1'b0;
      check("drain_count", {29'h0, Count}, 32'd0);
   endtask

   initial begin
      MR_n = 1'b0; Send_in = 1'b0; Data_in = '0; Dout_ready = 1'b0;
      tick(3);
      check("rst_ack", {31'h0, Ack_out}, 32'd0);
      check("rst_count", {29'h0, Count}, 32'd0);
      check("rst_valid", {31'h0, Dout_valid}, 32'd0);
      check("rst_dout", {16'h0, Dout}, 32'd0);
      MR_n = 1'b1;
      tick(4);

      // Single token: ack at edge 3, head valid at edge 4, ack low 3 edges after fall.
      Data_in = 16'hA5C3;
      Send_in = 1'b1;
      exp_q.push_back(16'hA5C3);
      tick(2);
      check("single_ack_e2", {31'h0, Ack_out}, 32'd0);
      tick(1);
      check("single_ack_e3", {31'h0, Ack_out}, 32'd1);
      check("single_valid_e3", {31'h0, Dout_valid}, 32'd0);
      tick(1);
      check("single_valid_e4", {31'h0, Dout_valid}, 32'd1);
      check("single_dout_e4", {16'h0, Dout}, 32'h0000A5C3);
      Send_in = 1'b0;
      tick(2);
      check("single_ackhold", {31'h0, Ack_out}, 32'd1);
      tick(1);
      check("single_ackfall", {31'h0, Ack_out}, 32'd0);
      check("single_count", {29'h0, Count}, 32'd1);
      drain();

      // Fill to DEPTH; the fifth token is held off until one pop.
      for (int k = 1; k <= 4; k++) send_token(DW'(k));
      check("fill_count", {29'h0, Count}, 32'd4);
      Data_in = 16'd5;
      Send_in = 1'b1;
      tick(6);
      check("full_ack_held", {31'h0, Ack_out}, 32'd0);
      check("full_count", {29'h0, Count}, 32'd4);
      Dout_ready = 1'b1;
      tick(1);
      Dout_ready = 1'b0;
      check("pop_count", {29'h0, Count}, 32'd3);
      check("pop_ack", {31'h0, Ack_out}, 32'd0);
      exp_q.push_back(16'd5);
      tick(1);
      check("tok5_ack", {31'h0, Ack_out}, 32'd1);
      check("tok5_count", {29'h0, Count}, 32'd4);
      check("tok5_dout", {16'h0, Dout}, 32'd2);
      Send_in = 1'b0;
      wait_ack(1'b0, 20);
      drain();

      // Push and pop on the same edge at Count=2.
      send_token(16'h0011);
      send_token(16'h0022);
      check("pp_count_pre", {29'h0, Count}, 32'd2);
      Data_in = 16'h0033;
      Send_in = 1'b1;
      exp_q.push_back(16'h0033);
      tick(2);
      Dout_ready = 1'b1;
      tick(1);
      Dout_ready = 1'b0;
      check("pp_ack", {31'h0, Ack_out}, 32'd1);
      check("pp_count", {29'h0, Count}, 32'd2);
      check("pp_dout", {16'h0, Dout}, 32'h22);
      Send_in = 1'b0;
      wait_ack(1'b0, 20);
      drain();

      // Streaming with the consumer always ready.
      Dout_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         send_token(DW'(k));
         check("stream_count_le1", {31'h0, (Count <= 1)}, 32'd1);
      end
      tick(4);
      check("stream_empty", exp_q.size(), 32'd0);
      Dout_ready = 1'b0;

      // Reset while acknowledging with Send_in still high.
      Data_in = 16'h0055;
      Send_in = 1'b1;
      wait_ack(1'b1, 20);
      #2;
      MR_n = 1'b0;
      #1;
      check("mr_ack", {31'h0, Ack_out}, 32'd0);
      check("mr_count", {29'h0, Count}, 32'd0);
      check("mr_valid", {31'h0, Dout_valid}, 32'd0);
      tick(2);
      MR_n = 1'b1;
      tick(8);
      check("resync_ack", {31'h0, Ack_out}, 32'd0);
      check("resync_count", {29'h0, Count}, 32'd0);
      check("resync_valid", {31'h0, Dout_valid}, 32'd0);
      Send_in = 1'b0;
      tick(5);
      Dout_ready = 1'b1;
      send_token(16'h0077);
      tick(4);
      check("post_rst_empty", exp_q.size(), 32'd0);
      check("post_rst_count", {29'h0, Count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
